ex_stage_reg: RTL and testbench
===============================

Name: ex_stage_reg

Overview:
- Consumer end of the ID/EX pipeline boundary.
- Takes the decoded fields that the ID/EX register presents and executes them.
- Computes the ALU result, the memory address and the branch target, and holds the NZCV status register.
- Registers the results into the EX/MEM boundary with 1-cycle latency.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- WORD_W, 32, datapath width (matches `WORD_WIDTH).
- DST_W, 4, register-index width (matches `REG_FILE_DEPTH).
- IMM_W, 24, branch signed-immediate width.
- SHOP_W, 12, shifter-operand width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- freeze  in  1  hold all state this cycle.
- flush  in  1  insert a bubble into EX/MEM.
- pc_in  in  WORD_W  PC+4 of the instruction.
- rn_val_in  in  WORD_W  Rn operand.
- rm_val_in  in  WORD_W  Rm operand, also the store data.
- dst_in  in  DST_W  destination register index.
- signed_imm_in  in  IMM_W  branch offset in words.
- shifter_operand_in  in  SHOP_W  immediate or shift specifier.
- ex_cmd_in  in  4  ALU opcode.
- mem_read_in, mem_write_in, wb_en_in, imm_in, b_in, update_in  in  1 each  control bits.
- alu_result  out  WORD_W  registered ALU result or memory address.
- store_data  out  WORD_W  registered Rm value.
- dst_out  out  DST_W  registered destination index.
- mem_read_out, mem_write_out, wb_en_out  out  1 each  registered control bits.
- status  out  4  NZCV register.
- branch_taken  out  1  combinational, equals b_in.
- branch_addr  out  WORD_W  combinational branch target.

Behaviour:
- Reset is asynchronous: all registered outputs and status go to 0 immediately and stay 0 while rst is high.
- Val2 (second operand):
  - imm_in=1: zero-extended shifter_operand_in[7:0] rotated right by 2*shifter_operand_in[11:8].
  - Else if mem_read_in or mem_write_in: zero-extended shifter_operand_in[11:0].
  - Else: rm_val_in shifted by shifter_operand_in[11:7], shift type shifter_operand_in[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); shift amount 0 means no shift.
- ALU, with op1 = rn_val_in:
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: op1+Val2.
  - 0011 ADC: op1+Val2+C.
  - 0100 SUB/CMP: op1-Val2.
  - 0101 SBC: op1-Val2-!C.
  - 0110 AND/TST: op1&Val2.
  - 0111 ORR: op1|Val2.
  - 1000 EOR: op1^Val2.
  - Any other code: result 0.
  - Loads and stores use the ADD code, so the address is Rn+Val2.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry-out of the 33-bit sum; for subtracts C = NOT borrow. V = signed overflow.
  - Logic ops and MOV/MVN: C and V unchanged.
- status loads the new flags at the edge only when update_in=1 and freeze=0.
- EX/MEM register:
  - freeze=1: everything holds, including status. freeze has priority over flush.
  - freeze=0 and flush=1: wb_en_out, mem_read_out and mem_write_out are set to 0; the data fields load normally; status does not update.
  - Otherwise all outputs load from the current cycle's inputs.
- branch_addr = pc_in + (sign-extend(signed_imm_in) << 2), wrap-around modulo 2^32. branch_taken = b_in, unregistered, so the hazard unit can flush in the same cycle.
- rst deasserting mid-stream: the first edge after release captures the current inputs normally.

Optional Feature:
- Macro: FWD_EN.
- Defined: adds ports sel_src1 and sel_src2 (in, 2 bits each) and mem_fwd_val and wb_fwd_val (in, WORD_W each).
  - Selector codes: 00 = register value, 01 = mem_fwd_val, 10 = wb_fwd_val, 11 = register value.
  - sel_src1 selects op1; sel_src2 selects the Rm value fed to both Val2 and store_data.
- Not defined: these ports do not exist and operands come directly from rn_val_in / rm_val_in.

Decomposition:
- Shared package sloth_pkg holds:
  - the EX command encodings (EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR);
  - the shift-type codes;
  - the width constants.
- One sub-module: val2_gen, purely combinational, producing Val2 from (imm_in, is_mem, shifter_operand_in, rm value).

Test Plan:
- ADD: rn=5, Val2 from imm 0x007, ex_cmd=0010, update=1 → next edge alu_result=12, status=0000.
- SUB with S: rn=3, imm 5, cmd 0100, update=1 → alu_result=0xFFFFFFFE, status N=1 Z=0 C=0 V=0. Then ADC 1+1 → alu_result=2 (C=0).
- Rotate immediate: imm_in=1, shifter_operand=0x4FF, cmd MOV → alu_result=0xFF000000.
- Register shift: rm=0x80000000, ASR #4, MOV → alu_result=0xF8000000.
- Branch: pc_in=0x100, signed_imm=0xFFFFFF, b_in=1 → branch_addr=0xFC, branch_taken=1 in the same cycle.
- Freeze, flush, reset:
  - freeze=1 for 2 cycles with changing inputs → outputs unchanged.
  - flush=1 with wb_en_in=1 and mem_write_in=1 → wb_en_out=0, mem_write_out=0.
  - rst pulsed mid-cycle → all outputs 0 before the next edge.

Source files
------------

// File: rtl/sloth_pkg.sv
// sloth_pkg: shared EX-stage encodings and width constants
// Holds the ALU command codes, the shifter-type codes, the forwarding
// selector codes and the default datapath widths.
package sloth_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_FILE_DEPTH = 4;
    localparam int IMM_WIDTH      = 24;
    localparam int SHOP_WIDTH     = 12;

    typedef enum logic [3:0] {
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } ex_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

endpackage

// File: rtl/ex_stage_reg_val2_gen.sv
// val2_gen: combinational second-operand generator for the EX stage
// Ports:
//   imm     in   immediate form (rotated 8-bit constant)
//   is_mem  in   load/store form (zero-extended 12-bit offset)
//   shop    in   shifter operand / immediate specifier
//   rm      in   register operand to shift
//   val2    out  resulting second operand
module val2_gen
    import sloth_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int SHOP_W = SHOP_WIDTH
) (
    input  logic              imm,
    input  logic              is_mem,
    input  logic [SHOP_W-1:0] shop,
    input  logic [WORD_W-1:0] rm,
    output logic [WORD_W-1:0] val2
);

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input logic [4:0] n);
        logic [2*WORD_W-1:0] d;
        d = {x, x} >> n;
        return d[WORD_W-1:0];
    endfunction

    logic [4:0]        amt;
    logic [WORD_W-1:0] imm_val;
    logic [WORD_W-1:0] asr_val;
    logic [WORD_W-1:0] reg_val;

    assign amt     = shop[11:7];
    assign imm_val = ror({{(WORD_W-8){1'b0}}, shop[7:0]}, {shop[11:8], 1'b0});
    // kept separate so the arithmetic shift stays signed
    assign asr_val = $signed(rm) >>> amt;

    always_comb begin
        reg_val = (amt == 5'd0)         ? rm :
                  (shop[6:5] == SH_LSL) ? rm << amt :
                  (shop[6:5] == SH_LSR) ? rm >> amt :
                  (shop[6:5] == SH_ASR) ? asr_val :
                                          ror(rm, amt);
        val2    = imm    ? imm_val :
                  is_mem ? {{(WORD_W-SHOP_W){1'b0}}, shop} :
                           reg_val;
    end

endmodule

// File: rtl/ex_stage_reg.sv
// ex_stage_reg: execute stage with NZCV status and EX/MEM pipeline register
// Optional operand forwarding is enabled by defining FWD_EN.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   freeze, flush              hold everything / bubble the EX/MEM controls
//   pc_in, signed_imm_in       branch target inputs (PC+4, word offset)
//   rn_val_in, rm_val_in       operands (Rm is also store data)
//   dst_in, shifter_operand_in destination index, Val2 specifier
//   ex_cmd_in                  ALU opcode
//   mem_read_in .. update_in   control bits
//   sel_src1/2, mem_fwd_val, wb_fwd_val   forwarding (FWD_EN only)
//   alu_result, store_data, dst_out, mem_read_out, mem_write_out,
//   wb_en_out                  registered EX/MEM outputs
//   status                     NZCV register
//   branch_taken, branch_addr  combinational branch outputs
module ex_stage_reg
    import sloth_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int DST_W  = REG_FILE_DEPTH,
    parameter int IMM_W  = IMM_WIDTH,
    parameter int SHOP_W = SHOP_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] rn_val_in,
    input  logic [WORD_W-1:0] rm_val_in,
    input  logic [DST_W-1:0]  dst_in,
    input  logic [IMM_W-1:0]  signed_imm_in,
    input  logic [SHOP_W-1:0] shifter_operand_in,
    input  logic [3:0]        ex_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              imm_in,
    input  logic              b_in,
    input  logic              update_in,
`ifdef FWD_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [WORD_W-1:0] mem_fwd_val,
    input  logic [WORD_W-1:0] wb_fwd_val,
`endif
    output logic [WORD_W-1:0] alu_result,
    output logic [WORD_W-1:0] store_data,
    output logic [DST_W-1:0]  dst_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic [3:0]        status,
    output logic              branch_taken,
    output logic [WORD_W-1:0] branch_addr
);

    logic [WORD_W-1:0] op1;
    logic [WORD_W-1:0] op2;
    logic [WORD_W-1:0] val2;
    logic [WORD_W-1:0] b_opnd;
    logic [WORD_W-1:0] res;
    logic [WORD_W:0]   sum;
    logic              is_sub;
    logic              is_arith;
    logic              cin;
    logic              v_new;
    logic [3:0]        flags;

`ifdef FWD_EN
    assign op1 = (sel_src1 == SEL_MEM) ? mem_fwd_val :
                 (sel_src1 == SEL_WB)  ? wb_fwd_val  : rn_val_in;
    assign op2 = (sel_src2 == SEL_MEM) ? mem_fwd_val :
                 (sel_src2 == SEL_WB)  ? wb_fwd_val  : rm_val_in;
`else
    assign op1 = rn_val_in;
    assign op2 = rm_val_in;
`endif

    val2_gen #(.WORD_W(WORD_W), .SHOP_W(SHOP_W)) u_val2 (
        .imm    (imm_in),
        .is_mem (mem_read_in | mem_write_in),
        .shop   (shifter_operand_in),
        .rm     (op2),
        .val2   (val2)
    );

    // One adder serves all four arithmetic ops: subtraction is op1 + ~Val2 + cin,
    // so the carry-out is directly the NOT-borrow C flag.
    always_comb begin
        is_sub   = (ex_cmd_in == EXE_SUB) || (ex_cmd_in == EXE_SBC);
        is_arith = is_sub || (ex_cmd_in == EXE_ADD) || (ex_cmd_in == EXE_ADC);
        b_opnd   = is_sub ? ~val2 : val2;
        cin      = (ex_cmd_in == EXE_SUB) ? 1'b1 :
                   ((ex_cmd_in == EXE_ADC) || (ex_cmd_in == EXE_SBC)) ? status[1] : 1'b0;
        sum      = {1'b0, op1} + {1'b0, b_opnd} + {{WORD_W{1'b0}}, cin};
        res      = is_arith                 ? sum[WORD_W-1:0] :
                   (ex_cmd_in == EXE_MOV)   ? val2 :
                   (ex_cmd_in == EXE_MVN)   ? ~val2 :
                   (ex_cmd_in == EXE_AND)   ? op1 & val2 :
                   (ex_cmd_in == EXE_ORR)   ? op1 | val2 :
                   (ex_cmd_in == EXE_EOR)   ? op1 ^ val2 : '0;
        v_new    = (op1[WORD_W-1] == b_opnd[WORD_W-1]) && (res[WORD_W-1] != op1[WORD_W-1]);
        flags    = {res[WORD_W-1], res == '0,
                    is_arith ? sum[WORD_W] : status[1],
                    is_arith ? v_new : status[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result    <= '0;
            store_data    <= '0;
            dst_out       <= '0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            wb_en_out     <= 1'b0;
            status        <= '0;
        end else if (!freeze) begin
            alu_result    <= res;
            store_data    <= op2;
            dst_out       <= dst_in;
            mem_read_out  <= mem_read_in & ~flush;
            mem_write_out <= mem_write_in & ~flush;
            wb_en_out     <= wb_en_in & ~flush;
            if (update_in && !flush)
                status <= flags;
        end
    end

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(WORD_W-IMM_W-2){signed_imm_in[IMM_W-1]}}, signed_imm_in, 2'b00};

endmodule

// File: tb/tb_ex_stage_reg.sv
// tb_ex_stage_reg: scoreboard bench for ex_stage_reg against a behavioural model
module tb_ex_stage_reg;
    import sloth_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, freeze = 1'b0, flush = 1'b0;
    logic [31:0] pc_in = '0, rn_val_in = '0, rm_val_in = '0;
    logic [3:0]  dst_in = '0, ex_cmd_in = '0;
    logic [23:0] signed_imm_in = '0;
    logic [11:0] shifter_operand_in = '0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0, wb_en_in = 1'b0;
    logic        imm_in = 1'b0, b_in = 1'b0, update_in = 1'b0;
`ifdef FWD_EN
    logic [1:0]  sel_src1 = 2'b00, sel_src2 = 2'b00;
    logic [31:0] mem_fwd_val = '0, wb_fwd_val = '0;
`endif
    logic [31:0] alu_result, store_data, branch_addr;
    logic [3:0]  dst_out, status;
    logic        mem_read_out, mem_write_out, wb_en_out, branch_taken;

    ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .rn_val_in(rn_val_in), .rm_val_in(rm_val_in),
        .dst_in(dst_in), .signed_imm_in(signed_imm_in),
        .shifter_operand_in(shifter_operand_in), .ex_cmd_in(ex_cmd_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
        .imm_in(imm_in), .b_in(b_in), .update_in(update_in),
`ifdef FWD_EN
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
        .alu_result(alu_result), .store_data(store_data), .dst_out(dst_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_en_out(wb_en_out),
        .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [3:0]  dst;
        logic        mr, mw, wb;
        logic [3:0]  st;
    } exp_t;

    exp_t q[$];
    exp_t m = '0;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rot(input logic [31:0] v, input int sh);
        longint unsigned x;
        x = v;
        return 32'(((x >> sh) | (x << (32 - sh))) & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] m_val2();
        longint unsigned x;
        int sh;
        if (imm_in)
            return rot({24'd0, shifter_operand_in[7:0]}, 2 * int'(shifter_operand_in[11:8]));
        if (mem_read_in || mem_write_in)
            return {20'd0, shifter_operand_in};
        sh = int'(shifter_operand_in[11:7]);
        x  = rm_val_in;
        if (sh == 0) return rm_val_in;
        case (shifter_operand_in[6:5])
            2'b00:   return 32'(x << sh);
            2'b01:   return 32'(x >> sh);
            2'b10:   return 32'(int'(rm_val_in) >>> sh);
            default: return rot(rm_val_in, sh);
        endcase
    endfunction

    // Arithmetic done in 64-bit integers: C from the unsigned range, V from the signed range.
    task automatic m_alu(input logic [31:0] v2, input logic [3:0] st,
                         output logic [31:0] r, output logic [3:0] ns);
        longint a, b, sa, sb, full, sfull;
        logic c, v;
        bit ar, add;
        a = longint'({32'd0, rn_val_in});
        b = longint'({32'd0, v2});
        sa = int'(rn_val_in);
        sb = int'(v2);
        c = st[1];
        v = st[0];
        ar = 1; add = 1; full = 0; sfull = 0; r = '0;
        case (ex_cmd_in)
            4'd2: begin full = a + b;     sfull = sa + sb; end
            4'd3: begin full = a + b + longint'(c); sfull = sa + sb + longint'(c); end
            4'd4: begin full = a - b;     sfull = sa - sb; add = 0; end
            4'd5: begin full = a - b - longint'(!c); sfull = sa - sb - longint'(!c); add = 0; end
            4'd1: begin ar = 0; r = v2; end
            4'd9: begin ar = 0; r = ~v2; end
            4'd6: begin ar = 0; r = rn_val_in & v2; end
            4'd7: begin ar = 0; r = rn_val_in | v2; end
            4'd8: begin ar = 0; r = rn_val_in ^ v2; end
            default: ar = 0;
        endcase
        if (ar) begin
            r = 32'(full);
            c = add ? (full > 64'sd4294967295) : (full >= 0);
            v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
        end
        ns = {r[31], r == 32'd0, c, v};
    endtask

    task automatic go();
        logic [31:0] r, exp_ba;
        logic [3:0]  ns;
        int s;
        #1;
        s = int'(signed_imm_in[23] ? {8'hFF, signed_imm_in} : {8'h00, signed_imm_in});
        exp_ba = 32'(longint'({32'd0, pc_in}) + 4 * longint'(s));
        chk("br_taken", branch_taken, b_in);
        chk("br_addr", branch_addr, exp_ba);
        m_alu(m_val2(), m.st, r, ns);
        if (!freeze) begin
            m.alu = r;
            m.sd  = rm_val_in;
            m.dst = dst_in;
            m.mr  = mem_read_in && !flush;
            m.mw  = mem_write_in && !flush;
            m.wb  = wb_en_in && !flush;
            if (update_in && !flush) m.st = ns;
        end
        q.push_back(m);
        @(negedge clk);
    endtask

    task automatic rand_in(input bit ctl);
        pc_in              = $urandom;
        rn_val_in          = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
        rm_val_in          = $urandom;
        dst_in             = 4'($urandom);
        signed_imm_in      = 24'($urandom);
        shifter_operand_in = 12'($urandom);
        ex_cmd_in          = 4'($urandom_range(0, 15));
        mem_read_in        = ($urandom_range(0, 4) == 0);
        mem_write_in       = ($urandom_range(0, 4) == 0);
        wb_en_in           = 1'($urandom);
        imm_in             = 1'($urandom);
        b_in               = 1'($urandom);
        update_in          = 1'($urandom);
        freeze             = ctl && ($urandom_range(0, 9) == 0);
        flush              = ctl && ($urandom_range(0, 9) == 0);
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic imm, input logic [31:0] rn,
                          input logic [31:0] rm, input logic [11:0] shop);
        ex_cmd_in = cmd; imm_in = imm; rn_val_in = rn; rm_val_in = rm;
        shifter_operand_in = shop; update_in = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; b_in = 1'b0; signed_imm_in = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                chk("alu_result", alu_result, e.alu);
                chk("store_data", store_data, e.sd);
                chk("dst_out", dst_out, e.dst);
                chk("ctrl", {mem_read_out, mem_write_out, wb_en_out}, {e.mr, e.mw, e.wb});
                chk("status", status, e.st);
            end
        end
    end

    initial begin : stim
        logic [31:0] hold_alu;
        logic [3:0]  hold_st;
        @(posedge clk);
        #1;
        chk("rst_outs", {alu_result, store_data, dst_out, mem_read_out, mem_write_out, wb_en_out}, '0);
        chk("rst_status", status, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        set_op(EXE_ADD, 1'b1, 32'd5, 32'd0, 12'h007); go();
        chk("add_res", alu_result, 32'd12);
        chk("add_st", status, 4'b0000);
        set_op(EXE_SUB, 1'b1, 32'd3, 32'd0, 12'h005); go();
        chk("sub_res", alu_result, 32'hFFFF_FFFE);
        chk("sub_st", status, 4'b1000);
        set_op(EXE_ADC, 1'b1, 32'd1, 32'd0, 12'h001); go();
        chk("adc_res", alu_result, 32'd2);
        set_op(EXE_MOV, 1'b1, 32'd0, 32'd0, 12'h4FF); go();
        chk("rot_imm", alu_result, 32'hFF00_0000);
        set_op(EXE_MOV, 1'b0, 32'd0, 32'h8000_0000, 12'h240); go();
        chk("asr4", alu_result, 32'hF800_0000);

        pc_in = 32'h100; signed_imm_in = 24'hFFFFFF; b_in = 1'b1;
        #1;
        chk("br_lit_addr", branch_addr, 32'hFC);
        chk("br_lit_taken", branch_taken, 1'b1);
        go();

        hold_alu = alu_result;
        hold_st  = status;
        repeat (2) begin
            rand_in(1'b0);
            freeze = 1'b1;
            update_in = 1'b1;
            go();
        end
        chk("frz_alu", alu_result, hold_alu);
        chk("frz_st", status, hold_st);
        freeze = 1'b0;

        rand_in(1'b0);
        flush = 1'b1; wb_en_in = 1'b1; mem_write_in = 1'b1;
        go();
        chk("flush_ctrl", {wb_en_out, mem_write_out}, 2'b00);
        flush = 1'b0;

        rand_in(1'b0);
        go();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {alu_result, store_data, dst_out, mem_read_out, mem_write_out, wb_en_out}, '0);
        chk("rst_mid_st", status, 4'b0000);
        m = '0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        repeat (400) begin
            rand_in(1'b1);
            go();
        end
        freeze = 1'b0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
